// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared types and default timing constants for the button move generator
package button_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 250000;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_PERIOD   = 10000000;

    function automatic int at_least_one(input int v);
        return (v < 1) ? 1 : v;
    endfunction

endpackage

// File: rtl/button_move_gen_if.sv
// rtl/button_move_gen_if.sv - raw button inputs and move strobe outputs of the move generator
interface button_move_gen_if;
    logic       btn_up_n;
    logic       btn_down_n;
    logic       btn_left_n;
    logic       btn_right_n;
    logic       move_up;
    logic       move_down;
    logic       move_left;
    logic       move_right;
    logic       active;
    logic [1:0] held_dir;

    modport master (
        input  btn_up_n, btn_down_n, btn_left_n, btn_right_n,
        output move_up, move_down, move_left, move_right, active, held_dir
    );

    modport slave (
        output btn_up_n, btn_down_n, btn_left_n, btn_right_n,
        input  move_up, move_down, move_left, move_right, active, held_dir
    );
endinterface

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - 2-flop synchronizer, debounce counter and press/release edge pulses for one button
module button_debounce
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press,
    output logic rel
);
    localparam int D_EFF = at_least_one(DEBOUNCE_CYCLES);
    localparam int CW    = $clog2(D_EFF + 1);

    logic          sync1, sync2;
    logic          deb, deb_q;
    logic [CW-1:0] cnt;
    logic [1:0]    fill;
    logic          armed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            deb   <= 1'b1;
            deb_q <= 1'b1;
            cnt   <= '0;
            fill  <= 2'b00;
            armed <= 1'b0;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
            fill  <= {fill[0], 1'b1};
            deb_q <= deb;
            if (sync2 != deb) begin
                if (cnt == CW'(D_EFF - 1)) begin
                    deb <= sync2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
            // A button held across reset stays disarmed until it is seen released.
            if ((deb && !deb_q) || (fill[1] && sync2 && deb))
                armed <= 1'b1;
        end
    end

    assign press = deb_q & ~deb & armed;
    assign rel   = ~deb_q & deb;

endmodule

// File: rtl/button_move_gen.sv
// rtl/button_move_gen.sv - debounced four-way button to single-cycle move strobes; BUTTON_AUTO_REPEAT_EN enables hold auto-repeat
module button_move_gen
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input logic               clk,
    input logic               rst,
    button_move_gen_if.master bus
);
    logic [3:0] btn_n, press, rel;
    logic [3:0] move_n, move_n_nxt;
    state_t     state, state_nxt;
    dir_t       held, held_nxt, sel;
    logic       rpt_fire;

    assign btn_n = {bus.btn_right_n, bus.btn_left_n, bus.btn_down_n, bus.btn_up_n};

    for (genvar i = 0; i < 4; i++) begin : g_deb
        button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk   (clk),
            .rst   (rst),
            .btn_n (btn_n[i]),
            .press (press[i]),
            .rel   (rel[i])
        );
    end

    // Checked lowest priority first so the highest-priority press wins.
    always_comb begin
        sel = DIR_RIGHT;
        if (press[2]) sel = DIR_LEFT;
        if (press[1]) sel = DIR_DOWN;
        if (press[0]) sel = DIR_UP;
    end

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int RD_EFF = at_least_one(REPEAT_DELAY);
    localparam int RP_EFF = at_least_one(REPEAT_PERIOD);
    localparam int RMAX   = (RD_EFF > RP_EFF) ? RD_EFF : RP_EFF;
    localparam int RW     = $clog2(RMAX + 1);

    logic [RW-1:0] rpt_cnt;

    // Loaded with value-1 so the strobe lands exactly DELAY/PERIOD cycles apart.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rpt_cnt <= '0;
        end else if (state == IDLE && |press) begin
            rpt_cnt <= RW'(RD_EFF - 1);
        end else if (state == HOLD) begin
            if (rpt_cnt == '0) rpt_cnt <= RW'(RP_EFF - 1);
            else               rpt_cnt <= rpt_cnt - RW'(1);
        end
    end

    assign rpt_fire = (rpt_cnt == '0);
`else
    assign rpt_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            held   <= DIR_UP;
            move_n <= 4'hF;
        end else begin
            state  <= state_nxt;
            held   <= held_nxt;
            move_n <= move_n_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        held_nxt  = held;
        case (state)
            IDLE: if (|press) begin
                state_nxt = HOLD;
                held_nxt  = sel;
            end
            HOLD: if (rel[held]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        move_n_nxt = 4'hF;
        if (state == IDLE && |press)
            move_n_nxt[sel] = 1'b0;
        else if (state == HOLD && !rel[held] && rpt_fire)
            move_n_nxt[held] = 1'b0;
    end

    assign bus.move_up    = move_n[0];
    assign bus.move_down  = move_n[1];
    assign bus.move_left  = move_n[2];
    assign bus.move_right = move_n[3];
    assign bus.active     = (state == HOLD);
    assign bus.held_dir   = (state == HOLD) ? held : DIR_UP;

endmodule

// File: tb/tb_button_move_gen.sv
// tb/tb_button_move_gen.sv - scoreboard bench for button_move_gen (DEBOUNCE 4, DELAY 10, PERIOD 5)
module tb_button_move_gen;

    typedef struct {
        int cyc;
        int dir;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] btn_n = 4'hF;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    exp_t       exp_q[$];

    button_move_gen_if bus ();

    assign bus.btn_up_n    = btn_n[0];
    assign bus.btn_down_n  = btn_n[1];
    assign bus.btn_left_n  = btn_n[2];
    assign bus.btn_right_n = btn_n[3];

    button_move_gen #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic to_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_strobe(input int c, input int d);
        exp_t e;
        e.cyc = c;
        e.dir = d;
        exp_q.push_back(e);
    endtask

    // Monitor: pops the scoreboard whenever a strobe appears, flags missed ones.
    always @(negedge clk) begin
        logic [3:0] lows;
        exp_t       e;
        lows = ~{bus.move_right, bus.move_left, bus.move_down, bus.move_up};
        if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_strobe actual none required dir %0d at cycle %0d", e.dir, e.cyc);
        end
        if (lows != 4'b0000) begin
            chk("strobe_onehot", $countones(lows), 1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe actual lows %b at cycle %0d required none", lows, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_dir", int'(lows), 1 << e.dir);
                chk("strobe_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int c;
        int s;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_moves", int'({bus.move_right, bus.move_left, bus.move_down, bus.move_up}), 15);
        chk("reset_active", int'(bus.active), 0);
        chk("reset_held_dir", int'(bus.held_dir), 0);
        rst = 1'b1;
        to_cyc(cyc + 6);

        // Clean up press, held past debounce, released.
        c = cyc;
        btn_n[0] = 1'b0;
        expect_strobe(c + 7, 0);
        to_cyc(c + 7);
        chk("up_active", int'(bus.active), 1);
        chk("up_held_dir", int'(bus.held_dir), 0);
        to_cyc(c + 10);
        btn_n[0] = 1'b1;
        to_cyc(c + 18);
        chk("up_release_active", int'(bus.active), 0);
        to_cyc(c + 22);

        // Left bouncing five times, then stable.
        for (int i = 0; i < 5; i++) begin
            btn_n[2] = 1'b0;
            to_cyc(cyc + 2);
            btn_n[2] = 1'b1;
            to_cyc(cyc + 1);
        end
        c = cyc;
        btn_n[2] = 1'b0;
        expect_strobe(c + 7, 2);
        to_cyc(c + 8);
        chk("left_held_dir", int'(bus.held_dir), 2);
        to_cyc(c + 10);
        btn_n[2] = 1'b1;
        to_cyc(c + 24);

        // Down and right together: down wins, right ignored.
        c = cyc;
        btn_n[1] = 1'b0;
        btn_n[3] = 1'b0;
        expect_strobe(c + 7, 1);
`ifdef BUTTON_AUTO_REPEAT_EN
        expect_strobe(c + 17, 1);
`endif
        to_cyc(c + 9);
        chk("down_held_dir", int'(bus.held_dir), 1);
        to_cyc(c + 12);
        btn_n[1] = 1'b1;
        to_cyc(c + 30);
        chk("right_ignored_active", int'(bus.active), 0);
        btn_n[3] = 1'b1;
        to_cyc(c + 40);

        // Right held; repeats at 10, 15..30; release coincides with the 35 expiry.
        c = cyc;
        s = c + 7;
        btn_n[3] = 1'b0;
        expect_strobe(s, 3);
`ifdef BUTTON_AUTO_REPEAT_EN
        for (int k = 10; k <= 30; k += 5) expect_strobe(s + k, 3);
`endif
        to_cyc(s + 1);
        chk("right_held_dir", int'(bus.held_dir), 3);
        to_cyc(s + 28);
        btn_n[3] = 1'b1;
        to_cyc(s + 40);
        chk("right_release_active", int'(bus.active), 0);

        // Reset mid-hold; held button needs release and re-press.
        c = cyc;
        btn_n[0] = 1'b0;
        expect_strobe(c + 7, 0);
        to_cyc(c + 10);
        chk("hold_before_reset", int'(bus.active), 1);
        rst = 1'b0;
        #1;
        chk("midreset_moves", int'({bus.move_right, bus.move_left, bus.move_down, bus.move_up}), 15);
        chk("midreset_active", int'(bus.active), 0);
        chk("midreset_held_dir", int'(bus.held_dir), 0);
        to_cyc(c + 13);
        rst = 1'b1;
        to_cyc(c + 35);
        chk("after_reset_active", int'(bus.active), 0);
        btn_n[0] = 1'b1;
        to_cyc(c + 45);
        c = cyc;
        btn_n[0] = 1'b0;
        expect_strobe(c + 7, 0);
        to_cyc(c + 8);
        chk("repress_active", int'(bus.active), 1);
        to_cyc(c + 10);
        btn_n[0] = 1'b1;
        to_cyc(c + 20);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
